// File: rtl/quad_decoder_if.sv
// Quadrature decoder signal bundle.
// master drives the raw inputs and controls, slave is the decoder.
interface quad_decoder_if #(
    parameter int ERR_W = 8
);
    logic             en;
    logic             a_in;
    logic             b_in;
    logic             err_clr;
    logic             up;
    logic             down;
    logic             err;
    logic [ERR_W-1:0] err_cnt;
    logic [1:0]       ab_filt;

    modport master (
        output en, a_in, b_in, err_clr,
        input  up, down, err, err_cnt, ab_filt
    );

    modport slave (
        input  en, a_in, b_in, err_clr,
        output up, down, err, err_cnt, ab_filt
    );
endinterface

// File: rtl/quad_decoder.sv
// Quadrature front end: sync, glitch filter, Gray-code decode.
// Emits 1-cycle up/down pulses and flags/counts illegal jumps.
module quad_decoder #(
    parameter int FILT_LEN = 4,
    parameter int ERR_W    = 8
) (
    input  logic          clk,
    input  logic          rstn,
    quad_decoder_if.slave bus
);
    localparam int CW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
    localparam logic [CW-1:0]    LAST = CW'(FILT_LEN - 1);
    localparam logic [ERR_W-1:0] EMAX = '1;

    typedef enum logic [1:0] {
        INIT0,
        INIT1,
        RUN
    } state_t;

    state_t           state;
    logic             s1a, s2a, s1b, s2b;
    logic [CW-1:0]    cnt_a, cnt_b;
    logic [1:0]       ab;
    logic             up_q, down_q, err_q;
    logic [ERR_W-1:0] ecnt;

    logic             acc_a, acc_b;
    logic [1:0]       ab_nxt, chg, ab_fwd;
    logic             is_up, is_dn, is_err;

    // Filter acceptance and old->new transition classification
    always_comb begin
        acc_a  = (s2a != ab[1]) && (cnt_a == LAST);
        acc_b  = (s2b != ab[0]) && (cnt_b == LAST);
        ab_nxt = {acc_a ? s2a : ab[1], acc_b ? s2b : ab[0]};
        chg    = ab ^ ab_nxt;
        ab_fwd = {ab[0], ~ab[1]};
        is_up  = 1'b0;
        is_dn  = 1'b0;
        is_err = 1'b0;
        unique case (1'b1)
            (chg == 2'b00):     ;
            (chg == 2'b11):     is_err = 1'b1;
            (ab_nxt == ab_fwd): is_up  = 1'b1;
            default:            is_dn  = 1'b1;
        endcase
    end

    // Two-flop synchroniser per channel
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s1a <= 1'b0;
            s2a <= 1'b0;
            s1b <= 1'b0;
            s2b <= 1'b0;
        end else begin
            s1a <= bus.a_in;
            s2a <= s1a;
            s1b <= bus.b_in;
            s2b <= s1b;
        end
    end

    // Start-up sequencing, glitch filters and registered pulses
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state  <= INIT0;
            ab     <= 2'b00;
            cnt_a  <= '0;
            cnt_b  <= '0;
            up_q   <= 1'b0;
            down_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            up_q   <= 1'b0;
            down_q <= 1'b0;
            err_q  <= 1'b0;
            unique case (state)
                INIT0: state <= INIT1;
                INIT1: begin
                    state <= RUN;
                    // s1 is what s2 holds after this edge
                    ab    <= {s1a, s1b};
                    cnt_a <= '0;
                    cnt_b <= '0;
                end
                RUN: begin
                    ab     <= ab_nxt;
                    cnt_a  <= (s2a == ab[1] || acc_a) ? '0 : cnt_a + CW'(1);
                    cnt_b  <= (s2b == ab[0] || acc_b) ? '0 : cnt_b + CW'(1);
                    up_q   <= bus.en & is_up;
                    down_q <= bus.en & is_dn;
                    err_q  <= bus.en & is_err;
                end
                default: state <= INIT0;
            endcase
        end
    end

    // Saturating error counter, clear has priority
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ecnt <= '0;
        end else if (bus.err_clr) begin
            ecnt <= '0;
        end else if (state == RUN && bus.en && is_err && ecnt != EMAX) begin
            ecnt <= ecnt + ERR_W'(1);
        end
    end

    assign bus.up      = up_q;
    assign bus.down    = down_q;
    assign bus.err     = err_q;
    assign bus.err_cnt = ecnt;
    assign bus.ab_filt = ab;
endmodule
